// File: rtl/julia_pkg.sv
// Shared types and constants for the Julia escape-time engine.
// Q4.12 fixed point: fx_t, escape threshold, FSM states, default mapping.
package julia_pkg;

  typedef logic signed [15:0] fx_t;

  localparam int FRAC_BITS   = 12;
  localparam int ESCAPE_MAG2 = 16384;
  localparam int MAG_W       = 21;

  localparam fx_t DEF_X_ORIGIN = -16'sd8192;
  localparam fx_t DEF_Y_ORIGIN = -16'sd6144;
  localparam fx_t DEF_STEP     = 16'sd26;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ITER,
    DONE
  } state_t;

endpackage

// File: rtl/julia_step.sv
// One combinational z <- z^2 + c step plus |z|^2 escape test.
// Ports: zr_i/zi_i current z, c_re_i/c_im_i constant;
//   zr_o/zi_o next z, mag2_o |z|^2 in Q.12, escaped_o mag2 > 4.0.
import julia_pkg::*;

module julia_step (
  input  fx_t                     zr_i,
  input  fx_t                     zi_i,
  input  fx_t                     c_re_i,
  input  fx_t                     c_im_i,
  output fx_t                     zr_o,
  output fx_t                     zi_o,
  output logic signed [MAG_W-1:0] mag2_o,
  output logic                    escaped_o
);

  localparam logic signed [MAG_W-1:0] ESC =
    MAG_W'(ESCAPE_MAG2);

  // 33 bits so zr^2 + zi^2 and 2*zr*zi never wrap.
  logic signed [32:0] rr;
  logic signed [32:0] ii;
  logic signed [32:0] ri;
  logic signed [32:0] sum;
  logic signed [32:0] dif;
  logic signed [32:0] dbl;
  logic signed [32:0] re_sh;
  logic signed [32:0] im_sh;

  assign rr  = 33'(zr_i) * 33'(zr_i);
  assign ii  = 33'(zi_i) * 33'(zi_i);
  assign ri  = 33'(zr_i) * 33'(zi_i);
  assign sum = rr + ii;
  assign dif = rr - ii;
  assign dbl = ri <<< 1;

  assign re_sh = dif >>> FRAC_BITS;
  assign im_sh = dbl >>> FRAC_BITS;

  assign zr_o = fx_t'(re_sh) + c_re_i;
  assign zi_o = fx_t'(im_sh) + c_im_i;

  assign mag2_o    = MAG_W'(sum >>> FRAC_BITS);
  assign escaped_o = mag2_o > ESC;

endmodule

// File: rtl/julia_iter.sv
// Per-pixel Julia escape-time engine: accept (x,y,c,max_iter), iterate, report.
// Ports: clk/n_rst, in_* request handshake, out_* result handshake.
import julia_pkg::*;

module julia_iter #(
  parameter int  X_W      = 10,
  parameter int  Y_W      = 9,
  parameter int  ITER_W   = 8,
  parameter fx_t X_ORIGIN = DEF_X_ORIGIN,
  parameter fx_t Y_ORIGIN = DEF_Y_ORIGIN,
  parameter fx_t STEP     = DEF_STEP
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [X_W-1:0]    x_value,
  input  logic [Y_W-1:0]    y_value,
  input  logic [15:0]       c_re,
  input  logic [15:0]       c_im,
  input  logic [ITER_W-1:0] max_iter,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ITER_W-1:0] iter_count,
  output logic [X_W-1:0]    out_x,
  output logic [Y_W-1:0]    out_y
);

  localparam logic signed [31:0] STEP32 = 32'(STEP);
  localparam logic signed [31:0] XO32   = 32'(X_ORIGIN);
  localparam logic signed [31:0] YO32   = 32'(Y_ORIGIN);

  state_t            st_q, st_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  fx_t               cre_q, cre_d;
  fx_t               cim_q, cim_d;
  logic [ITER_W-1:0] max_q, max_d;
  fx_t               zr_q, zr_d;
  fx_t               zi_q, zi_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;

  logic signed [31:0] x_ext;
  logic signed [31:0] y_ext;
  logic signed [31:0] zr_full;
  logic signed [31:0] zi_full;
  fx_t                zr_nx;
  fx_t                zi_nx;
  logic               esc;

  // Pixel to complex plane; result wraps to 16 bits.
  assign x_ext   = signed'({{(32-X_W){1'b0}}, x_q});
  assign y_ext   = signed'({{(32-Y_W){1'b0}}, y_q});
  assign zr_full = XO32 + x_ext * STEP32;
  assign zi_full = YO32 + y_ext * STEP32;

  julia_step u_step (
    .zr_i      (zr_q),
    .zi_i      (zi_q),
    .c_re_i    (cre_q),
    .c_im_i    (cim_q),
    .zr_o      (zr_nx),
    .zi_o      (zi_nx),
    .mag2_o    (),
    .escaped_o (esc)
  );

  always_comb begin
    st_d   = st_q;
    x_d    = x_q;
    y_d    = y_q;
    cre_d  = cre_q;
    cim_d  = cim_q;
    max_d  = max_q;
    zr_d   = zr_q;
    zi_d   = zi_q;
    iter_d = iter_q;
    cnt_d  = cnt_q;
    unique case (st_q)
      IDLE: begin
        if (in_valid) begin
          x_d   = x_value;
          y_d   = y_value;
          cre_d = c_re;
          cim_d = c_im;
          max_d = max_iter;
          st_d  = LOAD;
        end
      end
      LOAD: begin
        zr_d   = fx_t'(zr_full);
        zi_d   = fx_t'(zi_full);
        iter_d = '0;
        st_d   = ITER;
      end
      ITER: begin
        // Escape wins over the limit on the same z.
        if (esc) begin
          cnt_d = iter_q;
          st_d  = DONE;
        end else if (iter_q == max_q) begin
          cnt_d = max_q;
          st_d  = DONE;
        end else begin
          zr_d   = zr_nx;
          zi_d   = zi_nx;
          iter_d = iter_q + ITER_W'(1);
        end
      end
      DONE: begin
        if (out_ready) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      st_q   <= IDLE;
      x_q    <= '0;
      y_q    <= '0;
      cre_q  <= '0;
      cim_q  <= '0;
      max_q  <= '0;
      zr_q   <= '0;
      zi_q   <= '0;
      iter_q <= '0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      x_q    <= x_d;
      y_q    <= y_d;
      cre_q  <= cre_d;
      cim_q  <= cim_d;
      max_q  <= max_d;
      zr_q   <= zr_d;
      zi_q   <= zi_d;
      iter_q <= iter_d;
      cnt_q  <= cnt_d;
    end
  end

  assign in_ready   = (st_q == IDLE);
  assign out_valid  = (st_q == DONE);
  assign iter_count = cnt_q;
  assign out_x      = x_q;
  assign out_y      = y_q;

endmodule

// File: tb/tb_julia_iter.sv
// Directed bench for julia_iter: vector table plus stall and reset sequences.
// Expected counts and latencies are hand-computed from the Q4.12 recurrence.
module tb_julia_iter;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  x_value = '0;
  logic [8:0]  y_value = '0;
  logic [15:0] c_re = '0;
  logic [15:0] c_im = '0;
  logic [7:0]  max_iter = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  iter_count;
  logic [9:0]  out_x;
  logic [8:0]  out_y;

  int checks = 0;
  int errors = 0;

  julia_iter dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x_value    (x_value),
    .y_value    (y_value),
    .c_re       (c_re),
    .c_im       (c_im),
    .max_iter   (max_iter),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .iter_count (iter_count),
    .out_x      (out_x),
    .out_y      (out_y)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int cr;
    int ci;
    int mi;
    int cnt;
    int lat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic accept(input int x, input int y,
                        input int cr, input int ci,
                        input int mi);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    x_value  = 10'(x);
    y_value  = 9'(y);
    c_re     = 16'(cr);
    c_im     = 16'(ci);
    max_iter = 8'(mi);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 300);
    if (!out_valid) chk("result_timeout", 0, 1);
  endtask

  initial begin
    int lat;
    int sx;
    int sy;
    int sc;

    // z0=(128,96), c=0: shrinks to 0, bounded.
    vecs[0] = '{320, 240, 0, 0, 50, 50, 52};
    // z0=(-2.0,-1.5): mag2=25600, escapes at once.
    vecs[1] = '{0, 0, 0, 0, 50, 0, 2};
    // z0=(6160,-8): mag2 9264, z1=(9263,-25) mag2 20948.
    vecs[2] = '{552, 236, 0, 0, 50, 1, 3};
    // max_iter=0 on a bounded point.
    vecs[3] = '{320, 240, 0, 0, 0, 0, 2};
    // Far corner: z0=(8422,6310), mag2 27037.
    vecs[4] = '{639, 479, 0, 0, 50, 0, 2};
    // c=1.0: z1=(4097,6) mag2 4098, z2=(8193,12) mag2 16388.
    vecs[5] = '{320, 240, 4096, 0, 5, 2, 4};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_iter_count", 32'(iter_count), 0);
    chk("rst_out_x", 32'(out_x), 0);
    chk("rst_out_y", 32'(out_y), 0);
    @(negedge clk);
    n_rst = 1'b1;

    out_ready = 1'b1;
    foreach (vecs[i]) begin
      accept(vecs[i].x, vecs[i].y, vecs[i].cr,
             vecs[i].ci, vecs[i].mi);
      wait_result(lat);
      chk($sformatf("v%0d_count", i), 32'(iter_count),
          32'(vecs[i].cnt));
      chk($sformatf("v%0d_latency", i), 32'(lat),
          32'(vecs[i].lat));
      chk($sformatf("v%0d_out_x", i), 32'(out_x),
          32'(vecs[i].x));
      chk($sformatf("v%0d_out_y", i), 32'(out_y),
          32'(vecs[i].y));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_one_valid", i), 32'(out_valid), 0);
      chk($sformatf("v%0d_ready_back", i), 32'(in_ready), 1);
    end

    // Stall in DONE while offering new requests.
    out_ready = 1'b0;
    accept(320, 240, 4096, 0, 5);
    wait_result(lat);
    chk("stall_latency", 32'(lat), 4);
    sx = 320;
    sy = 240;
    sc = 2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = k[0] ? 1'b0 : 1'b1;
      x_value  = 10'(11 + k);
      y_value  = 9'(22 + k);
      max_iter = 8'd0;
      @(posedge clk);
      #1;
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_count", 32'(iter_count), 32'(sc));
      chk("stall_x", 32'(out_x), 32'(sx));
      chk("stall_y", 32'(out_y), 32'(sy));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release_valid", 32'(out_valid), 0);
    chk("stall_release_ready", 32'(in_ready), 1);
    chk("stall_no_capture_x", 32'(out_x), 32'(sx));

    // Reset while iterating the bounded pixel at iter=10.
    accept(320, 240, 0, 0, 50);
    repeat (11) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_ready", 32'(in_ready), 1);
    chk("mid_rst_count", 32'(iter_count), 0);
    chk("mid_rst_x", 32'(out_x), 0);
    chk("mid_rst_y", 32'(out_y), 0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (out_valid) chk("mid_rst_no_result", 32'(out_valid), 0);
    end

    accept(0, 0, 0, 0, 50);
    wait_result(lat);
    chk("post_rst_count", 32'(iter_count), 0);
    chk("post_rst_latency", 32'(lat), 2);
    chk("post_rst_x", 32'(out_x), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
